sar_linear_search: RTL and testbench
====================================

// Module: sar_linear_search
// PURPOSE
//  Parametrised successive-approximation search controller for the linear map y = Y0 - SLOPE*x.
//  Given a target, it finds the XW-bit code x whose y is nearest the target, after clamping the target
//  to the reachable range. It adds a rounding step, abort, busy and error outputs over the 4-bit
//  fixed-map controller, and sits between a target source and the code-driven load.
// PARAMETERS
//  XW     4     code width; search takes XW trial cycles
//  YW     10    target/y/err width; Y0 < 2**YW required
//  Y0     1000  y at x=0
//  SLOPE  30    y decrement per code LSB; Y0 >= SLOPE*(2**XW-1) required (elaboration check)
// PORTS
//  clk     in   1   rising-edge clock
//  rst_n   in   1   asynchronous active-low reset
//  start   in   1   request; sampled only in IDLE
//  abort   in   1   cancel an active search
//  target  in   YW  requested y, unsigned
//  busy    out  1   high from the cycle after start is accepted until done/abort
//  done    out  1   one-cycle pulse, result valid
//  x       out  XW  result code; held until the next completion
//  y       out  YW  Y0 - SLOPE*x for the result
//  err     out  YW  |y - clamped target|
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=0, done=0, x=0, y=0, err=0.
//  - YMIN = Y0 - SLOPE*(2**XW-1). On accept, latch tgt = clamp(target, YMIN, Y0).
//  - IDLE: start=1 and abort=0 -> latch tgt, trial=1<<(XW-1), idx=XW-1, go to SEARCH. abort wins over start.
//  - SEARCH (one bit per cycle): keep the trial bit if Y0-SLOPE*trial >= tgt, else clear it.
//    If idx==0 -> ROUND; else set bit idx-1 and decrement idx.
//  - The search yields xg = the largest x with y(x) >= tgt.
//  - ROUND (1 cycle): pick xg+1 if xg < 2**XW-1 and y(xg)-tgt > tgt-y(xg+1); else pick xg.
//    Ties go to the smaller x.
//  - ROUND then registers x, y and err, pulses done, and returns to IDLE.
//  - Latency: start sampled at edge k -> done high after edge k+XW+1. busy is high after edges k+1..k+XW.
//  - start while busy: ignored, no queueing. A new start is accepted in the cycle done is high (state is IDLE).
//  - abort in SEARCH or ROUND: IDLE at the next edge, no done, and x/y/err keep their previous result.
//  - Arithmetic: evaluate y in YW bits. The parameter check guarantees no underflow.
//    err is computed from the registered clamped tgt, never the raw target.
// CONFIGURATION
//  SAR_EARLY_EXIT_EN defined:
//    - In SEARCH, if y(trial) == tgt, register x=trial, y=tgt, err=0, pulse done at that edge,
//      and skip the remaining bits and ROUND. Latency is variable, between 1 and XW+1 cycles.
//  Undefined: latency is always exactly XW+1 cycles.
// STRUCTURE
//  - Package sar_pkg holds:
//    - state encoding localparams (IDLE, SEARCH, ROUND);
//    - function lin_y(x) = Y0 - SLOPE*x;
//    - function clamp_tgt.
//  - Sub-module sar_lin_eval: combinational y from x.
//    - One instance evaluates the trial; a second evaluates xg+1 for ROUND.
//  - Everything else (FSM, idx counter, result registers) stays in this module.
// TESTING (default params)
//  - target=630: trials 8,12,14,13 -> xg=12, round 10 vs 20 -> x=12, y=640, err=10; done 5 cycles after start.
//  - target=625: tie (15 vs 15) -> x=12, y=640, err=15.
//  - target=400 -> clamp 550 -> x=15, y=550, err=0.
//  - target=1023 -> clamp 1000 -> x=0, y=1000, err=0.
//  - target=700:
//    - macro off: x=10, y=700, err=0, done at +5;
//    - SAR_EARLY_EXIT_EN on: trials 8,12,10 -> done at +3.
//  - start=630 then abort at +2 -> no done, x/y/err unchanged, busy low after the next edge.
//  - start pulsed while busy -> ignored.
//  - rst_n low mid-SEARCH -> all outputs 0 immediately.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared state encoding and arithmetic helpers for the linear-map SAR search controller.
package sar_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_ROUND  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SEARCH = ST_SEARCH,
    ROUND  = ST_ROUND
  } state_t;

  function automatic int unsigned lin_y(input int unsigned x, input int unsigned y0,
                                        input int unsigned slope);
    return y0 - slope * x;
  endfunction

  function automatic int unsigned clamp_tgt(input int unsigned t, input int unsigned lo,
                                            input int unsigned hi);
    if (t < lo) return lo;
    if (t > hi) return hi;
    return t;
  endfunction

endpackage

// File: rtl/sar_lin_eval.sv
// Combinational evaluation of y = Y0 - SLOPE*x in YW bits.
module sar_lin_eval
  import sar_pkg::*;
#(
  parameter int XW    = 4,
  parameter int YW    = 10,
  parameter int Y0    = 1000,
  parameter int SLOPE = 30
) (
  input  logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  assign y = YW'(lin_y(32'(x), Y0, SLOPE));

endmodule

// File: rtl/sar_linear_search.sv
// SAR search controller for y = Y0 - SLOPE*x with rounding, abort, busy and err outputs.
// Optional SAR_EARLY_EXIT_EN: finish as soon as a trial hits the target exactly.
module sar_linear_search
  import sar_pkg::*;
#(
  parameter int XW    = 4,
  parameter int YW    = 10,
  parameter int Y0    = 1000,
  parameter int SLOPE = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [YW-1:0] target,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [YW-1:0] err
);

  localparam int XMAX = 2**XW - 1;
  localparam int YMIN = Y0 - SLOPE * XMAX;
  localparam int IW   = (XW > 1) ? $clog2(XW) : 1;
  localparam logic [XW-1:0] X_ALL = XW'(XMAX);

  if (Y0 >= 2**YW || Y0 < SLOPE * XMAX) begin : g_bad_params
    $error("sar_linear_search: map does not fit YW bits or underflows");
  end

  state_t        state_reg, state_next;
  logic [XW-1:0] trial_reg, trial_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [YW-1:0] tgt_reg, tgt_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [YW-1:0] err_reg, err_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;

  logic [YW-1:0] y_trial, y_up, d_lo, d_hi;
  logic [XW-1:0] x_up, bit_mask, kept;
  logic          take_up;

  // In ROUND trial_reg holds xg, so this instance also provides y(xg).
  sar_lin_eval #(.XW(XW), .YW(YW), .Y0(Y0), .SLOPE(SLOPE)) u_eval_trial (
    .x (trial_reg),
    .y (y_trial)
  );

  assign x_up = trial_reg + XW'(1);

  sar_lin_eval #(.XW(XW), .YW(YW), .Y0(Y0), .SLOPE(SLOPE)) u_eval_up (
    .x (x_up),
    .y (y_up)
  );

  assign bit_mask = XW'(1) << idx_reg;
  assign kept     = (y_trial >= tgt_reg) ? trial_reg : (trial_reg & ~bit_mask);
  assign d_lo     = y_trial - tgt_reg;
  assign d_hi     = tgt_reg - y_up;
  // Strict compare sends ties to the smaller code.
  assign take_up  = (trial_reg != X_ALL) && (d_lo > d_hi);

  always_comb begin
    state_next = state_reg;
    trial_next = trial_reg;
    idx_next   = idx_reg;
    tgt_next   = tgt_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    err_next   = err_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          tgt_next   = YW'(clamp_tgt(32'(target), YMIN, Y0));
          trial_next = XW'(1) << (XW - 1);
          idx_next   = IW'(XW - 1);
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        if (abort) begin
          state_next = IDLE;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (y_trial == tgt_reg) begin
          x_next     = trial_reg;
          y_next     = tgt_reg;
          err_next   = '0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
`endif
        else if (idx_reg == '0) begin
          trial_next = kept;
          state_next = ROUND;
        end else begin
          trial_next = kept | (bit_mask >> 1);
          idx_next   = idx_reg - IW'(1);
        end
      end
      ROUND: begin
        state_next = IDLE;
        if (!abort) begin
          x_next    = take_up ? x_up : trial_reg;
          y_next    = take_up ? y_up : y_trial;
          err_next  = take_up ? d_hi : d_lo;
          done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Low in the first search cycle and again on the edge that finishes or aborts.
    busy_next = (state_reg != IDLE) && (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      trial_reg <= '0;
      idx_reg   <= '0;
      tgt_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      err_reg   <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      trial_reg <= trial_next;
      idx_reg   <= idx_next;
      tgt_reg   <= tgt_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign x    = x_reg;
  assign y    = y_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_sar_linear_search.sv
// Scoreboard bench for sar_linear_search (default parameters); honours SAR_EARLY_EXIT_EN.
module tb_sar_linear_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [9:0] target;
  logic       busy;
  logic       done;
  logic [3:0] x;
  logic [9:0] y;
  logic [9:0] err;

  sar_linear_search dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .target (target),
    .busy   (busy),
    .done   (done),
    .x      (x),
    .y      (y),
    .err    (err)
  );

  typedef struct {
    int ex;
    int ey;
    int ee;
    int due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

`ifdef SAR_EARLY_EXIT_EN
  localparam int LAT_400 = 4;
  localparam int LAT_700 = 3;
`else
  localparam int LAT_400 = 5;
  localparam int LAT_700 = 5;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with x=%0d expected none (cycle %0d)", x, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("done at cycle %0d: x=%0d y=%0d err=%0d", cyc, x, y, err);
        chk("result_x", int'(x), e.ex);
        chk("result_y", int'(y), e.ey);
        chk("result_err", int'(err), e.ee);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic issue(input int t, output int k);
    @(negedge clk);
    start  = 1'b1;
    target = 10'(t);
    @(posedge clk);
    #1;
    start = 1'b0;
    k = cyc;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 20) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic run(input int t, input int ex, input int ey, input int ee, input int lat);
    int k;
    issue(t, k);
    sb.push_back('{ex: ex, ey: ey, ee: ee, due: k + lat});
    $display("start target=%0d at cycle %0d, expect x=%0d y=%0d err=%0d", t, k, ex, ey, ee);
    if (lat >= 3) begin
      @(posedge clk);
      #1;
      chk("busy_mid", int'(busy), 1);
    end
    drain("drain_timeout");
    chk("busy_after", int'(busy), 0);
  endtask

  initial begin
    int k;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(630, 12, 640, 10, 5);
    run(625, 12, 640, 15, 5);
    run(400, 15, 550, 0, LAT_400);
    run(1023, 0, 1000, 0, 5);
    run(700, 10, 700, 0, LAT_700);

    // Abort two edges into a search: no done, previous result retained.
    issue(630, k);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    @(negedge clk);
    abort = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_x", int'(x), 10);
    chk("abort_y", int'(y), 700);
    chk("abort_err", int'(err), 0);
    $display("abort issued at cycle %0d: x=%0d y=%0d err=%0d", k, x, y, err);

    // A second start while busy must be ignored.
    issue(630, k);
    sb.push_back('{ex: 12, ey: 640, ee: 10, due: k + 5});
    @(negedge clk);
    start  = 1'b1;
    target = 10'd700;
    @(negedge clk);
    start = 1'b0;
    drain("drain_busy_start");
    repeat (8) @(posedge clk);
    #1;
    chk("ignored_start_x", int'(x), 12);
    $display("start-while-busy check at cycle %0d: x=%0d", cyc, x);

    // Asynchronous reset in the middle of a search.
    issue(1023, k);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x", int'(x), 0);
    chk("mid_rst_y", int'(y), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    $display("reset mid-search at cycle %0d", cyc);
    @(negedge clk);
    rst_n = 1'b1;

    run(625, 12, 640, 15, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
